// File: rtl/timer_arbiter_if.sv
// Requester/counter-side signal bundle for timer_arbiter; requesters and the shared
// flex_counter sit on the master side, the arbiter on the slave side.
interface timer_arbiter_if #(parameter int NUM_CNT_BITS = 4);
  logic                    req_a;
  logic [NUM_CNT_BITS-1:0] len_a;
  logic                    req_b;
  logic [NUM_CNT_BITS-1:0] len_b;
  logic                    grant_a;
  logic                    grant_b;
  logic                    done_a;
  logic                    done_b;
  logic                    busy;
  logic                    cnt_clear;
  logic                    cnt_enable;
  logic [NUM_CNT_BITS-1:0] cnt_rollover_val;
  logic                    cnt_rollover_flag;

  modport master (
    output req_a, len_a, req_b, len_b, cnt_rollover_flag,
    input  grant_a, grant_b, done_a, done_b, busy, cnt_clear, cnt_enable, cnt_rollover_val
  );

  modport slave (
    input  req_a, len_a, req_b, len_b, cnt_rollover_flag,
    output grant_a, grant_b, done_a, done_b, busy, cnt_clear, cnt_enable, cnt_rollover_val
  );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin owner of one shared flex_counter for requesters A/B; done pulses len+3 cycles
// after the request is seen (2 for len=0). Losing requester simply waits while its req is held.
module timer_arbiter #(
  parameter int NUM_CNT_BITS = 4
) (
  input logic            clk,
  input logic            n_rst,
  timer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;   // 0 = A, 1 = B
  logic                    prio_q, prio_d;     // requester that wins a tie
  logic [NUM_CNT_BITS-1:0] roll_q, roll_d;
  logic                    owner_req;
  logic                    pick;
  logic                    grant;
  logic                    done;
  logic                    clear;
  logic                    enable;

  assign owner_req = owner_q ? bus.req_b : bus.req_a;
  assign pick      = (bus.req_a && bus.req_b) ? prio_q : bus.req_b;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      roll_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      roll_q  <= roll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    roll_d  = roll_q;
    grant   = 1'b0;
    done    = 1'b0;
    clear   = 1'b0;
    enable  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          owner_d = pick;
          roll_d  = pick ? bus.len_b : bus.len_a;
          state_d = LOAD;
        end
      end
      LOAD: begin
        grant = 1'b1;
        clear = 1'b1;
        if (!owner_req) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end else if (roll_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        grant = 1'b1;
        if (!owner_req) begin
          // Abort: leave the counter cleared for the next owner.
          clear   = 1'b1;
          prio_d  = ~owner_q;
          state_d = IDLE;
        end else begin
          // Holding enable low on the flag cycle keeps the counter from wrapping.
          enable = !bus.cnt_rollover_flag;
          if (bus.cnt_rollover_flag) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        grant   = 1'b1;
        done    = 1'b1;
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant_a          = grant & ~owner_q;
  assign bus.grant_b          = grant &  owner_q;
  assign bus.done_a           = done  & ~owner_q;
  assign bus.done_b           = done  &  owner_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.cnt_clear        = clear;
  assign bus.cnt_enable       = enable;
  assign bus.cnt_rollover_val = roll_q;

endmodule
